dsp_mult_arbiter: RTL

- Round-robin arbiter that shares one pipelined 8x8 DSP48 multiplier between NREQ independent requesters.
- Each requester offers an operand pair through a valid/ready handshake.
- At most one pair is issued into the multiplier pipeline per cycle.
- Each product returns on a single tagged response port that honours downstream backpressure.
- Sits between the operand sources and the DSP multiplier in the basic-mult test designs.

---
 rtl/dsp_mult_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/dsp_mult_arbiter.sv
// -----------------------------------------------------------------------------
// dsp_mult_arbiter
//
// Round-robin arbiter that shares one pipelined unsigned 8x8 multiplier
// between NREQ requesters. At most one operand pair is accepted per cycle.
// Each product leaves LATENCY cycles later on a single tagged response port
// that honours downstream backpressure.
//
// Ports:
//   clk         system clock
//   rst         synchronous, active-high reset
//   req_valid   per-requester operand valid            [NREQ]
//   req_ready   per-requester accept, one-hot or zero  [NREQ]
//   req_a       factor A, requester i at [8i+7:8i]     [NREQ*8]
//   req_b       factor B, same packing as req_a        [NREQ*8]
//   rsp_valid   response valid
//   rsp_ready   downstream accepts the response
//   rsp_id      index of the requester owning the response [IDW]
//   rsp_result  product, zero-extended from 16 bits    [18]
// -----------------------------------------------------------------------------
module dsp_mult_arbiter #(
   parameter int NREQ    = 4,
   parameter int IDW     = 2,
   parameter int LATENCY = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*8-1:0]   req_a,
   input  logic [NREQ*8-1:0]   req_b,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [IDW-1:0]      rsp_id,
   output logic [17:0]         rsp_result
);

   logic             w_adv;
   logic             w_found;
   logic             w_fire;
   logic [IDW-1:0]   w_gnt_idx;
   logic [IDW-1:0]   w_scan_idx;
   int               w_scan_sum;
   logic [7:0]       w_a;
   logic [7:0]       w_b;
   logic [15:0]      w_prod;

   logic [IDW-1:0]   r_last;
   logic             r_vld  [LATENCY];
   logic [IDW-1:0]   r_id   [LATENCY];
   logic [15:0]      r_prod [LATENCY];

   // The whole pipeline moves only when the output slot is empty or is
   // being consumed this cycle.
   assign w_adv = !r_vld[LATENCY-1] || rsp_ready;

   // Round-robin scan starting just after the last granted requester.
   always_comb begin
      w_found    = 1'b0;
      w_gnt_idx  = '0;
      w_scan_idx = '0;
      w_scan_sum = 0;
      for (int k = 1; k <= NREQ; k++) begin
         w_scan_sum = int'(r_last) + k;
         w_scan_idx = IDW'((w_scan_sum >= NREQ) ? (w_scan_sum - NREQ) : w_scan_sum);
         if (!w_found && req_valid[w_scan_idx]) begin
            w_found   = 1'b1;
            w_gnt_idx = w_scan_idx;
         end else begin
            w_found   = w_found;
         end
      end
   end

   // Grant is suppressed during reset and while the pipeline is stalled, so
   // a held request simply waits for the first cycle the pipeline moves.
   always_comb begin
      req_ready = '0;
      if (w_adv && !rst && w_found) begin
         req_ready = {{(NREQ-1){1'b0}}, 1'b1} << w_gnt_idx;
      end else begin
         req_ready = '0;
      end
   end

   assign w_fire = |(req_valid & req_ready);

   // Operand mux for the granted requester; the plain multiply lets synthesis
   // absorb the following pipeline registers into the DSP block.
   assign w_a    = req_a[{w_gnt_idx, 3'b000} +: 8];
   assign w_b    = req_b[{w_gnt_idx, 3'b000} +: 8];
   assign w_prod = {8'd0, w_a} * {8'd0, w_b};

   // Pipeline stages, output register and round-robin pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last <= IDW'(NREQ - 1);
         for (int i = 0; i < LATENCY; i++) begin
            r_vld[i]  <= 1'b0;
            r_id[i]   <= '0;
            r_prod[i] <= 16'd0;
         end
      end else if (w_adv) begin
         // Empty slots carry zeros so an idle output reads as all-zero.
         r_vld[0]  <= w_fire;
         r_id[0]   <= w_fire ? w_gnt_idx : '0;
         r_prod[0] <= w_fire ? w_prod : 16'd0;
         for (int i = 1; i < LATENCY; i++) begin
            r_vld[i]  <= r_vld[i-1];
            r_id[i]   <= r_id[i-1];
            r_prod[i] <= r_prod[i-1];
         end
         if (w_fire) begin
            r_last <= w_gnt_idx;
         end
      end
   end

   assign rsp_valid  = r_vld[LATENCY-1];
   assign rsp_id     = r_id[LATENCY-1];
   assign rsp_result = {2'b00, r_prod[LATENCY-1]};

endmodule
